// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads to imem, buffers the
// returned words in an in-order queue and presents {pc, instr} to decode.
// Taken branches/jumps redirect the PC; responses to wrong-path requests that
// are still outstanding are counted in drop_q and discarded on return.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | just out of reset, no requests issued
//   ST_FETCH | normal fetch, nothing pending to discard
//   ST_DRAIN | wrong-path responses still outstanding; new path may issue
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [6:0]  if_opcode
);

    localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    // inflight can reach drop (<= BUF_DEPTH) plus BUF_DEPTH live requests
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;

    // PCs of live (not-to-be-dropped) outstanding requests, oldest first
    logic [31:0]   aq_pc_q [BUF_DEPTH];
    logic [31:0]   aq_pc_d [BUF_DEPTH];
    logic [PW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;

    // instruction queue presented to decode
    logic [31:0]   dq_pc_q  [BUF_DEPTH];
    logic [31:0]   dq_pc_d  [BUF_DEPTH];
    logic [31:0]   dq_ins_q [BUF_DEPTH];
    logic [31:0]   dq_ins_d [BUF_DEPTH];
    logic [PW-1:0] dq_wr_q, dq_wr_d, dq_rd_q, dq_rd_d;
    logic [PW:0]   dq_cnt_q, dq_cnt_d;

    logic          valid_w;
    logic          pop;
    logic          req_valid;
    logic          req_fire;
    logic          rsp_any;
    logic          rsp_drop;
    logic          rsp_keep;
    logic          push;
    logic [CW-1:0] credit;
    logic [31:0]   head_pc;
    logic [31:0]   head_ins;

    // Handshake qualifiers and the request credit check
    always_comb begin
        valid_w  = (dq_cnt_q != '0);
        pop      = valid_w && if_ready;
        // A slot freed by this cycle's pop is refilled no earlier than next
        // cycle, so it can be lent to a new request; this keeps 1 instr/cycle.
        credit   = inflight_q - drop_q + CW'(dq_cnt_q) - CW'(pop);
        req_valid = (state_q != ST_IDLE) && !redirect_valid && (credit < DEPTH_C);
        req_fire = req_valid && imem_req_ready;
        rsp_any  = imem_rsp_valid && (inflight_q != '0);
        rsp_drop = rsp_any && (drop_q != '0);
        rsp_keep = rsp_any && (drop_q == '0);
        push     = rsp_keep && !redirect_valid;
    end

    // Next-state for PC, counters, FSM and both queues
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_any);
        drop_d     = drop_q - CW'(rsp_drop);
        aq_pc_d    = aq_pc_q;
        aq_wr_d    = aq_wr_q;
        aq_rd_d    = aq_rd_q;
        dq_pc_d    = dq_pc_q;
        dq_ins_d   = dq_ins_q;
        dq_wr_d    = dq_wr_q;
        dq_rd_d    = dq_rd_q;
        dq_cnt_d   = dq_cnt_q;

        if (req_fire) begin
            pc_d             = pc_q + 32'd4;
            aq_pc_d[aq_wr_q] = pc_q;
            aq_wr_d          = aq_wr_q + PW'(1);
        end

        if (rsp_keep) begin
            aq_rd_d = aq_rd_q + PW'(1);
        end

        if (push) begin
            dq_pc_d[dq_wr_q]  = aq_pc_q[aq_rd_q];
            dq_ins_d[dq_wr_q] = imem_rsp_data;
            dq_wr_d           = dq_wr_q + PW'(1);
        end

        if (pop) begin
            dq_rd_d = dq_rd_q + PW'(1);
        end

        dq_cnt_d = dq_cnt_q + (PW+1)'(push) - (PW+1)'(pop);

        if (redirect_valid && (state_q != ST_IDLE)) begin
            // every request still outstanding after this edge is wrong-path
            pc_d     = redirect_pc & 32'hFFFF_FFFC;
            drop_d   = inflight_d;
            aq_rd_d  = aq_wr_d;
            dq_rd_d  = dq_wr_d;
            dq_cnt_d = '0;
        end

        if (state_q == ST_IDLE) begin
            state_d = ST_FETCH;
        end else begin
            state_d = (drop_d != '0) ? ST_DRAIN : ST_FETCH;
        end
    end

    // All state registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            aq_wr_q    <= '0;
            aq_rd_q    <= '0;
            dq_wr_q    <= '0;
            dq_rd_q    <= '0;
            dq_cnt_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                aq_pc_q[i]  <= '0;
                dq_pc_q[i]  <= '0;
                dq_ins_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            aq_wr_q    <= aq_wr_d;
            aq_rd_q    <= aq_rd_d;
            dq_wr_q    <= dq_wr_d;
            dq_rd_q    <= dq_rd_d;
            dq_cnt_q   <= dq_cnt_d;
            aq_pc_q    <= aq_pc_d;
            dq_pc_q    <= dq_pc_d;
            dq_ins_q   <= dq_ins_d;
        end
    end

    // Decode-facing outputs read zero while the queue is empty
    always_comb begin
        head_pc  = valid_w ? dq_pc_q[dq_rd_q]  : 32'h0;
        head_ins = valid_w ? dq_ins_q[dq_rd_q] : 32'h0;
    end

    assign imem_req_valid = req_valid;
    assign imem_addr      = pc_q;
    assign if_valid       = valid_w;
    assign if_pc          = head_pc;
    assign if_instr       = head_ins;
    assign if_opcode      = head_ins[6:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: an in-order imem model returns a PC-tagged
// word per request, and a scoreboard tracks the PC decode must see next.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [6:0]  if_opcode;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_opcode      (if_opcode)
    );

    int          n_chk = 0;
    int          n_err = 0;
    int          deliv_cnt = 0;
    logic [31:0] exp_next = 32'h0;
    logic [31:0] mq [$];
    bit          rsp_en = 1'b1;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {~a[24:0], a[8:2]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: sample handshakes just after the negedge inputs settle,
    // score deliveries, then advance the imem model at the following negedge.
    task automatic cycle();
        logic        acc;
        logic [31:0] acc_addr;
        logic        rsp_taken;
        logic        was_rst;
        logic [31:0] tmp;
        #1;
        was_rst   = rst;
        acc       = imem_req_valid && imem_req_ready;
        acc_addr  = imem_addr;
        rsp_taken = imem_rsp_valid;
        if (!was_rst) begin
            if (if_valid) begin
                tmp = instr_of(if_pc);
                chk("opcode", {25'b0, if_opcode}, {25'b0, tmp[6:0]});
            end
            if (if_valid && if_ready) begin
                chk("pc_seq", if_pc, exp_next);
                chk("instr", if_instr, instr_of(exp_next));
                exp_next = exp_next + 32'd4;
                deliv_cnt++;
            end
            if (redirect_valid) exp_next = redirect_pc & 32'hFFFF_FFFC;
        end else begin
            exp_next = 32'h0;
        end
        @(posedge clk);
        @(negedge clk);
        if (was_rst) begin
            mq.delete();
        end else begin
            if (rsp_taken && mq.size() > 0) void'(mq.pop_front());
            if (acc) mq.push_back(acc_addr);
        end
        imem_rsp_valid = rsp_en && (mq.size() > 0);
        imem_rsp_data  = (mq.size() > 0) ? instr_of(mq[0]) : 32'h0;
    endtask

    task automatic wait_valid(input int budget, input string tag, input logic [31:0] exp_pc);
        int k;
        k = 0;
        while (!if_valid && k < budget) begin
            cycle();
            k++;
        end
        if (!if_valid) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else           chk(tag, if_pc, exp_pc);
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        cycle();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic        v [7];
        logic [31:0] p [7];
        logic [31:0] hold_pc, hold_ins;
        logic        prev_stall;
        logic [31:0] prev_pc;

        rst = 1'b1;
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        if_ready       = 1'b1;
        @(negedge clk);
        repeat (3) cycle();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);

        // 1: first if_valid two cycles after the first edge seeing rst low
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            v[i] = if_valid;
            p[i] = if_pc;
            cycle();
        end
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t1_valid%0d", i), {31'b0, v[i]}, (i >= 3) ? 32'd1 : 32'd0);
        end
        for (int i = 3; i < 7; i++) begin
            chk($sformatf("t1_pc%0d", i), p[i], 32'(4 * (i - 3)));
        end

        // 2: decode stall holds the output and throttles requests
        if_ready = 1'b0;
        #1;
        hold_pc  = if_pc;
        hold_ins = if_instr;
        for (int i = 0; i < 5; i++) begin
            chk("t2_hold_pc", if_pc, hold_pc);
            chk("t2_hold_instr", if_instr, hold_ins);
            cycle();
            #1;
        end
        chk("t2_req_throttled", {31'b0, imem_req_valid}, 32'd0);
        chk("t2_still_valid", {31'b0, if_valid}, 32'd1);
        if_ready = 1'b1;
        repeat (6) cycle();

        // 3: redirect with two requests outstanding
        rsp_en = 1'b0;
        repeat (4) cycle();
        #1;
        chk("t3_two_inflight_noreq", {31'b0, imem_req_valid}, 32'd0);
        chk("t3_queue_empty", {31'b0, if_valid}, 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        chk("t3_no_req_in_redirect", {31'b0, imem_req_valid}, 32'd0);
        cycle();
        redirect_valid = 1'b0;
        rsp_en = 1'b1;
        wait_valid(20, "t3_first", 32'h100);
        cycle();
        wait_valid(20, "t3_second", 32'h104);
        repeat (4) cycle();

        // 4: redirect coincides with a response
        chk("t4_rsp_present", {31'b0, imem_rsp_valid}, 32'd1);
        redirect_to(32'h300);
        wait_valid(20, "t4_first", 32'h300);
        repeat (3) cycle();

        // 5: unaligned target and PC wrap
        redirect_to(32'h203);
        #1;
        chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("t5_addr_aligned", imem_addr, 32'h200);
        wait_valid(20, "t5_first", 32'h200);
        repeat (3) cycle();
        redirect_to(32'hFFFF_FFFC);
        wait_valid(20, "t5_wrap_a", 32'hFFFF_FFFC);
        cycle();
        wait_valid(20, "t5_wrap_b", 32'h0);
        repeat (3) cycle();

        // mid-run reset
        rst = 1'b1;
        repeat (2) cycle();
        #1;
        chk("rst2_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst2_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst2_if_pc", if_pc, 32'h0);
        rst = 1'b0;
        wait_valid(20, "rst2_first", 32'h0);

        // 6: random imem ready, response gaps and decode stalls
        deliv_cnt  = 0;
        prev_stall = 1'b0;
        prev_pc    = 32'h0;
        for (int i = 0; i < 400; i++) begin
            if (prev_stall) chk("t6_hold", if_pc, prev_pc);
            imem_req_ready = ($urandom_range(0, 1) == 1);
            if_ready       = ($urandom_range(0, 3) != 0);
            rsp_en         = ($urandom_range(0, 3) != 0);
            prev_stall     = if_valid && !if_ready;
            prev_pc        = if_pc;
            cycle();
        end
        chk("t6_progress", {31'b0, deliv_cnt >= 50}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
